// File: rtl/input_capture_16_pkg.sv
// Shared defaults and width helpers for the input-capture block.
package capture_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int LVL_W_DEF = PTR_W_DEF + 1;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/input_capture_16_if.sv
// Consumer-side handshake for captured counts.
interface capture_if #(parameter int WIDTH = capture_pkg::WIDTH_DEF) ();

  logic [WIDTH-1:0] cap_data;
  logic             cap_valid;
  logic             cap_ready;

  modport master (output cap_data, output cap_valid, input cap_ready);
  modport slave  (input cap_data, input cap_valid, output cap_ready);

endinterface

// File: rtl/input_capture_16_sync.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic n_reset,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // prev resets low, so a pin held high through reset still yields one pulse
  assign rise = sync2 & ~prev;

endmodule

// File: rtl/input_capture_16.sv
// Timestamps rising edges of an async pin with an upstream count into a FWFT FIFO.
module input_capture_16
  import capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     event_in,
  capture_if.master                cap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  // DEPTH must be a power of two so the pointers wrap naturally
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic             edge_pulse;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;

  sync_edge_det u_sync (
    .clk      (clk),
    .n_reset  (n_reset),
    .async_in (event_in),
    .rise     (edge_pulse)
  );

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  always_comb begin
    push_req = edge_pulse & enable;
    full     = (level == FULL_LVL);
    pop      = cap.cap_valid & cap.cap_ready;
    push     = push_req & (~full | pop);
  end

  assign cap.cap_valid = (level != '0);
  assign cap.cap_data  = cap.cap_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Set has priority over the software clear
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      overflow <= 1'b0;
    end else if (push_req & full & ~pop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= count_in;
  end

endmodule

// File: doc/input_capture_16.md
INPUT_CAPTURE_16 -- requirements
Module: input_capture_16

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which sets the width of the captured count.
REQ-002 The module SHALL have parameter DEPTH, default 4, which sets the capture FIFO depth; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge clocked.
REQ-004 The module SHALL have port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: capture enable.
REQ-006 The module SHALL have port count_in, input, WIDTH bits: free-running count from the upstream synchronous up-counter Q output.
REQ-007 The module SHALL have port event_in, input, 1 bit: asynchronous external event pin.
REQ-008 The module SHALL have port cap_data, output, WIDTH bits: oldest captured count.
REQ-009 The module SHALL have port cap_valid, output, 1 bit: cap_data holds a valid entry.
REQ-010 The module SHALL have port cap_ready, input, 1 bit: the consumer accepts cap_data.
REQ-011 The module SHALL have port level, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-012 The module SHALL have port overflow, output, 1 bit: sticky flag for a dropped capture.
REQ-013 The module SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.

Function
REQ-014 event_in SHALL pass through a 2-flop synchronizer, then a rising-edge detector (sync2=1, prev=0); these run regardless of enable.
REQ-015 A detected edge with enable=1 SHALL push the count_in value present at that same clock edge; an edge with enable=0 SHALL be discarded.
REQ-016 Latency SHALL be: event_in rises before edge N; the push occurs at edge N+2; cap_valid=1 after edge N+2.
REQ-017 A pop SHALL occur on any clock edge where cap_valid=1 and cap_ready=1; cap_data SHALL then advance to the next entry, or cap_valid SHALL fall if the FIFO empties.
REQ-018 cap_data SHALL be read combinationally from the head entry (first-word fall-through); cap_data and cap_valid SHALL be stable while cap_valid=1 and cap_ready=0.
REQ-019 A push when full with no pop SHALL drop the new value, leave the contents unchanged, and set overflow at that edge.
REQ-020 A push and a pop in the same cycle when full SHALL both be accepted, leaving level=DEPTH and overflow unchanged.
REQ-021 A push and a pop in the same cycle at any level 1..DEPTH-1 SHALL leave level unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be exact in 0..DEPTH.
REQ-023 count_in wrap-around (0xFFFF to 0x0000) SHALL require no special handling: the raw value is stored.
REQ-024 clr_overflow=1 SHALL clear overflow at the next edge; if an overflow event occurs in the same cycle, set SHALL win.
REQ-025 Back-to-back edges SHALL each be captured; with the synchronizer, the minimum spacing is one clock high plus one clock low.

Reset
REQ-026 n_reset=0 SHALL immediately clear: synchronizer and prev flops to 0, pointers to 0, level to 0, cap_valid to 0, and overflow to 0.
REQ-027 cap_data SHALL read as 0 during reset; FIFO storage itself SHALL NOT be reset.
REQ-028 An event_in held high through reset release SHALL be treated as a rising edge and captured 2 edges after release if enable=1.
REQ-029 A reset asserted mid-operation SHALL discard all stored entries; no partial pop or push SHALL survive.

Structure
REQ-030 Package capture_pkg SHALL hold the WIDTH and DEPTH defaults and the derived pointer and level widths.
REQ-031 Sub-module sync_edge_det (2-flop synchronizer plus rising-edge pulse, async active-low reset) SHALL be instantiated once.
REQ-032 The FIFO SHALL be inline: a register array, a read pointer, a write pointer, and a level counter.

Verification
REQ-033 count_in ramps from 0x0100; event pulse applied; cap_ready=0 -> cap_valid rises at edge N+2 with cap_data equal to count_in at edge N+2, and level=1.
REQ-034 Five events with cap_ready=0 -> level=4, overflow=1, and the 4 oldest values are popped in order; the 5th value is absent.
REQ-035 FIFO full, then push and pop in the same cycle -> level stays 4, overflow stays 0, and the order is preserved.
REQ-036 enable=0 during an event -> no capture and level=0; enable=1 with event_in already high -> no capture until the next rising edge.
REQ-037 count_in=0xFFFF at one capture and 0x0002 at the next -> values read back as 0xFFFF then 0x0002.
REQ-038 n_reset pulsed low for 26 clocks with 3 entries stored -> cap_valid=0, level=0, and overflow=0 immediately; normal captures resume after release.
